// File: rtl/dp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_pipe
// Brief    : Dual-port RAM with one byte-enabled synchronous write port and
//            one pipelined read port. Provides valid/error flags, selectable
//            read-during-write behaviour, address-window checking and an
//            optional zeroing sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_DEPTH      = 16,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    rd_err,
    output logic                    wr_err,
    output logic                    init_done
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    // Storage array: intentionally not reset
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    // Control state
    state_t                r_state;
    logic [c_IDX_W-1:0]    r_clr_idx;
    logic                  r_init_done;
    logic                  r_wr_err;

    // Read pipeline: stage READ_LATENCY-1 drives the outputs directly
    logic                  r_pv [READ_LATENCY];
    logic                  r_pe [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];

    // Address decode
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic [ADDR_WIDTH-1:0] w_rd_off;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_clr_we;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // An address below the base wraps to an offset >= RAM_DEPTH, so a single
    // unsigned compare on the offset checks both ends of the window.
    assign w_wr_off = wr_addr - c_BASE;
    assign w_rd_off = rd_addr - c_BASE;
    assign w_wr_in  = ({1'b0, w_wr_off} < c_DEPTH);
    assign w_rd_in  = ({1'b0, w_rd_off} < c_DEPTH);
    assign w_wr_idx = w_wr_off[c_IDX_W-1:0];
    assign w_rd_idx = w_rd_off[c_IDX_W-1:0];

    assign w_wr_acc = wr_en & r_init_done;
    assign w_rd_acc = rd_en & r_init_done;

    // The sweep must not touch the array while reset is held
    assign w_clr_we = (r_state == S_CLEAR) & ~rst;

    assign w_old = r_mem[w_rd_idx];

    generate
        if (RDW_MODE != 0) begin : g_rdw_new
            logic w_same;
            assign w_same = w_wr_acc & w_wr_in & (wr_addr == rd_addr);

            // Forward enabled write bytes into a same-address read
            always_comb begin
                w_rd_word = w_old;
                if (w_same) begin
                    for (int b = 0; b < c_BYTES; b++) begin
                        if (wr_be[b]) begin
                            w_rd_word[8*b +: 8] = data_in[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : g_rdw_old
            assign w_rd_word = w_old;
        end
    endgenerate

    // Array update: zeroing sweep during clear, byte-masked writes when ready
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr_acc && w_wr_in) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (wr_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    // Init FSM: sweep every word once, then stay ready until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_RST_STATE;
            r_clr_idx   <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_clr_idx   <= '0;
                        r_state     <= S_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_idx   <= r_clr_idx + c_IDX_W'(1);
                    end
                end
                S_READY: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= c_RST_STATE;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-window write flag, one cycle after the offending write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_acc & ~w_wr_in;
        end
    end

    // Read pipeline; data stages only load behind a valid so the output holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_acc;
            r_pe[0] <= w_rd_acc & ~w_rd_in;
            if (w_rd_acc) begin
                r_pd[0] <= w_rd_in ? w_rd_word : '0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    assign data_out  = r_pd[READ_LATENCY-1];
    assign rd_valid  = r_pv[READ_LATENCY-1];
    assign rd_err    = r_pe[READ_LATENCY-1];
    assign wr_err    = r_wr_err;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: doc/dp_ram_pipe.md
Name: dp_ram_pipe

Overview:
Parametrised dual-port RAM: one synchronous write port with byte enables, one synchronous pipelined read port with configurable latency and valid/error flags. Adds selectable read-during-write semantics, address-window checking with error pulses, and an optional hardware clear sequence after reset. Drop-in storage for FIFOs, register files and packet buffers that need registered, timing-friendly reads.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
RAM_DEPTH, 16, number of words; must be >= 2.
BASE_ADDR, 0, first valid address; valid window is BASE_ADDR .. BASE_ADDR+RAM_DEPTH-1.
ADDR_WIDTH, 8, address bus width; must cover BASE_ADDR+RAM_DEPTH-1.
READ_LATENCY, 1, cycles from read request edge to rd_valid; legal 1..3.
RDW_MODE, 0, same-address read/write on the same edge: 0 returns old data, 1 returns new (byte-merged) data.
CLEAR_ON_RESET, 1, 1 zeroes every word after reset release; 0 skips clearing.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous active-high reset.
wr_en  input  1  write request.
wr_addr  input  ADDR_WIDTH  write address.
wr_be  input  DATA_WIDTH/8  byte enables; bit i gates data_in[8i+7:8i].
data_in  input  DATA_WIDTH  write data.
rd_en  input  1  read request.
rd_addr  input  ADDR_WIDTH  read address.
data_out  output  DATA_WIDTH  read data, valid when rd_valid=1.
rd_valid  output  1  one-cycle pulse per accepted read, READ_LATENCY cycles after request.
rd_err  output  1  qualifies rd_valid: read address was outside the window.
wr_err  output  1  one-cycle pulse the cycle after an accepted out-of-window write.
init_done  output  1  high when the RAM accepts requests.

Behaviour:
- Reset (asynchronous, active-high): data_out=0, rd_valid=0, rd_err=0, wr_err=0, init_done=0; read pipeline flushed; FSM to CLEAR (CLEAR_ON_RESET=1) or READY-pending (CLEAR_ON_RESET=0); clear index=0. Array contents are not reset by rst itself.
- FSM states: CLEAR, READY.
  - CLEAR: each edge writes 0 to BASE_ADDR+index, index++. On the edge clearing index RAM_DEPTH-1, go to READY. Exactly RAM_DEPTH edges after rst release.
  - READY: init_done=1. CLEAR_ON_RESET=0: READY, init_done=1 on the first edge after release.
- Requests while init_done=0 are ignored: no array write, no rd_valid, no error pulses.
- Write, accepted on edge with wr_en=1 and init_done=1: in-window writes update only bytes with wr_be=1; wr_be=0 is a legal no-op. Out-of-window writes are dropped; wr_err=1 for the following cycle.
- Read, accepted on edge with rd_en=1 and init_done=1: address captured. After READ_LATENCY edges: rd_valid=1 for one cycle, data_out=word. Out-of-window: data_out=0, rd_err=1. rd_err=0 whenever rd_valid=0.
- Back-to-back reads every cycle are fully pipelined: one rd_valid per request, in order, no bubbles.
- data_out holds its last value while rd_valid=0.
- Same-address read and write on one edge: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns pre-write word with enabled bytes replaced by data_in.
- Different addresses on the same edge: independent, no interaction.
- rst asserted mid-operation: in-flight reads are discarded (no rd_valid), clear restarts from index 0; a partial clear leaves unspecified contents until the rerun completes.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, RAM_DEPTH=16 -> init_done rises exactly 16 edges after release; reads of all 16 addresses return 0x00000000, rd_err=0.
- READ_LATENCY=2: write 0xDEADBEEF to addr 3 (wr_be=4'hF), then wr_be=4'b0010 with 0x0000AA00 -> read addr 3 gives 0xDEADAAEF with rd_valid exactly 2 cycles after the request.
- RDW_MODE=0 then 1: addr 5 holds 0x11111111; simultaneous write 0x22222222 (wr_be=4'hF) and read addr 5 -> data_out 0x11111111 (mode 0) / 0x22222222 (mode 1).
- BASE_ADDR=0x10, RAM_DEPTH=16: write addr 0x20 -> wr_err pulse next cycle, no array change; read addr 0x0F -> rd_valid=1, rd_err=1, data_out=0.
- READ_LATENCY=3: reads addr 0..7 on consecutive cycles -> eight consecutive rd_valid pulses, in order, starting 3 cycles after first request.
- Assert rst with 2 reads in flight and clear at index 7 -> no rd_valid emerges; after release init_done rises 16 edges later; requests during clear ignored.
